// File: rtl/bep_frame_transmit.sv
// BEP link transmitter: latches a 192-bit frame from its field inputs and sends it
// MSB-first as IEEE Manchester on manchester_out, with a matching NRZ data/strobe pair.
module bep_frame_transmit #(
  parameter int unsigned HALF_BIT_CYCLES = 8,
  parameter int unsigned GAP_HALF_BITS   = 4,
  parameter logic        IDLE_LEVEL      = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] preamble,
  input  logic [15:0] type_1,
  input  logic [15:0] type_2,
  input  logic [31:0] constant,
  input  logic [31:0] thermostat_id,
  input  logic [15:0] room_temp,
  input  logic [15:0] set_temp,
  input  logic [7:0]  state,
  input  logic [7:0]  tail_1,
  input  logic [7:0]  tail_2,
  input  logic [7:0]  tail_3,
  output logic        busy,
  output logic        done,
  output logic        manchester_out,
  output logic        serial_data,
  output logic        serial_clock
);

  localparam int unsigned BIT_CYC = 2 * HALF_BIT_CYCLES;
  localparam int unsigned GAP_CYC = GAP_HALF_BITS * HALF_BIT_CYCLES;
  localparam int unsigned CNT_MAX = (BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_PT  = CW'(HALF_BIT_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [7:0]    LAST_BIT = 8'd191;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [191:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     bit_q, bit_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           man_q, man_d;
  logic           sd_q, sd_d;
  logic           sc_q, sc_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d = {preamble, type_1, type_2, constant, thermostat_id,
                     room_temp, set_temp, state, tail_1, tail_2, tail_3};
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          end else begin
            shift_d = {shift_q[190:0], 1'b0};
            bit_d   = bit_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are derived from next-state values so every pin is a flop yet
  // reflects the bit that starts in the following cycle.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    man_d  = IDLE_LEVEL;
    sd_d   = 1'b0;
    sc_d   = 1'b0;
    if (state_d == ST_SEND) begin
      sd_d  = shift_d[191];
      sc_d  = (cnt_d >= HALF_PT);
      man_d = sc_d ? shift_d[191] : ~shift_d[191];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      man_q   <= IDLE_LEVEL;
      sd_q    <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      man_q   <= man_d;
      sd_q    <= sd_d;
      sc_q    <= sc_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign manchester_out = man_q;
  assign serial_data    = sd_q;
  assign serial_clock   = sc_q;

endmodule

// File: tb/tb_bep_frame_transmit.sv
// Directed/random bench for bep_frame_transmit: per-cycle line and strobe checks
// against a frame-level timing model plus an NRZ loopback decoder.
module tb_bep_frame_transmit;

  localparam int unsigned H = 2;
  localparam int unsigned G = 4;
  localparam logic        IDLE_LVL = 1'b0;
  localparam int          LAST_SEND = 384 * H;
  localparam int          END_GAP   = LAST_SEND + G * H;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] preamble, constant, thermostat_id;
  logic [15:0] type_1, type_2, room_temp, set_temp;
  logic [7:0]  state, tail_1, tail_2, tail_3;
  logic        busy, done, manchester_out, serial_data, serial_clock;

  int total = 0;
  int bad   = 0;

  bep_frame_transmit #(
    .HALF_BIT_CYCLES(H),
    .GAP_HALF_BITS  (G),
    .IDLE_LEVEL     (IDLE_LVL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .preamble      (preamble),
    .type_1        (type_1),
    .type_2        (type_2),
    .constant      (constant),
    .thermostat_id (thermostat_id),
    .room_temp     (room_temp),
    .set_temp      (set_temp),
    .state         (state),
    .tail_1        (tail_1),
    .tail_2        (tail_2),
    .tail_3        (tail_3),
    .busy          (busy),
    .done          (done),
    .manchester_out(manchester_out),
    .serial_data   (serial_data),
    .serial_clock  (serial_clock)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_man"},  manchester_out, IDLE_LVL);
    chk({tag, "_sd"},   serial_data, 1'b0);
    chk({tag, "_sc"},   serial_clock, 1'b0);
  endtask

  task automatic clear_fields();
    preamble = '0; type_1 = '0; type_2 = '0; constant = '0; thermostat_id = '0;
    room_temp = '0; set_temp = '0; state = '0; tail_1 = '0; tail_2 = '0; tail_3 = '0;
  endtask

  task automatic rand_fields();
    preamble = $urandom; type_1 = 16'($urandom); type_2 = 16'($urandom);
    constant = $urandom; thermostat_id = $urandom; room_temp = 16'($urandom);
    set_temp = 16'($urandom); state = 8'($urandom); tail_1 = 8'($urandom);
    tail_2 = 8'($urandom); tail_3 = 8'($urandom);
  endtask

  // Called just before a rising edge; returns at the negedge of the done cycle
  // (or after an abort), with dec holding the bits seen on serial_clock rises.
  task automatic send_frame(input int pulse_at, input int abort_at, input bit hold,
                            output logic [191:0] dec);
    logic [191:0] exp_f;
    logic ebusy, edone, eman, esd, esc, bitv, prev_sc;
    int nsc, b;
    exp_f = {preamble, type_1, type_2, constant, thermostat_id,
             room_temp, set_temp, state, tail_1, tail_2, tail_3};
    dec = '0; nsc = 0; prev_sc = 1'b0;
    start = 1'b1;
    @(posedge clock);
    #1;
    rand_fields();
    start = hold;
    for (int k = 1; k <= END_GAP + 1; k++) begin
      @(negedge clock);
      if (k <= LAST_SEND) begin
        b     = (k - 1) / (2 * H);
        esc   = ((k - 1) % (2 * H)) >= H;
        bitv  = exp_f[191 - b];
        ebusy = 1'b1; edone = 1'b0; esd = bitv;
        eman  = esc ? bitv : ~bitv;
      end else if (k <= END_GAP) begin
        ebusy = 1'b1; edone = 1'b0; esd = 1'b0; esc = 1'b0; eman = IDLE_LVL;
      end else begin
        ebusy = 1'b0; edone = 1'b1; esd = 1'b0; esc = 1'b0; eman = IDLE_LVL;
      end
      chk("busy", busy, ebusy);
      chk("done", done, edone);
      chk("man",  manchester_out, eman);
      chk("sd",   serial_data, esd);
      chk("sc",   serial_clock, esc);
      if (serial_clock && !prev_sc) begin
        dec = {dec[190:0], serial_data};
        nsc++;
      end
      prev_sc = serial_clock;
      if (k == abort_at) begin
        #2 reset = 1'b1;
        #1 chk_idle("abort_async", 1'b0);
        repeat (2) begin
          @(negedge clock);
          chk_idle("abort_hold", 1'b0);
        end
        #1 reset = 1'b0;
        start = 1'b0;
        repeat (2) begin
          @(negedge clock);
          chk_idle("abort_after", 1'b0);
        end
        return;
      end
      start = (k == pulse_at) ? 1'b1 : hold;
    end
    chk("sc_edges", nsc, 192);
    chk("frame", dec, exp_f);
  endtask

  logic [191:0] dec;
  logic [31:0]  lb_const, lb_type;
  logic [15:0]  lb_set;
  logic [7:0]   lb_state;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clear_fields();
    @(negedge clock);
    chk_idle("rst", 1'b0);
    #1 reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      chk_idle("post_rst", 1'b0);
    end

    // First bit: 1 then 0s
    clear_fields();
    preamble = 32'h8000_0000;
    send_frame(-1, -1, 1'b0, dec);
    chk("first_bits", dec[191:184], 8'h80);

    // Field order: tail_3 is last on the wire
    clear_fields();
    tail_3 = 8'hA5;
    send_frame(-1, -1, 1'b0, dec);
    chk("tail3", dec[7:0], 8'hA5);

    // start while busy is ignored, reset at 200 aborts
    rand_fields();
    send_frame(100, 200, 1'b0, dec);

    rand_fields();
    send_frame(-1, -1, 1'b0, dec);

    // start held high: back-to-back frames
    rand_fields();
    send_frame(-1, -1, 1'b1, dec);
    rand_fields();
    send_frame(-1, -1, 1'b0, dec);

    // Loopback decode of each field
    rand_fields();
    preamble = 32'hAAAA_AAAA; thermostat_id = 32'h1234_5678; room_temp = 16'h00D2;
    lb_const = constant; lb_type = {type_1, type_2}; lb_set = set_temp; lb_state = state;
    send_frame(-1, -1, 1'b0, dec);
    chk("lb_preamble", dec[191:160], 32'hAAAA_AAAA);
    chk("lb_types",    dec[159:128], lb_type);
    chk("lb_constant", dec[127:96],  lb_const);
    chk("lb_tid",      dec[95:64],   32'h1234_5678);
    chk("lb_room",     dec[63:48],   16'h00D2);
    chk("lb_set",      dec[47:32],   lb_set);
    chk("lb_state",    dec[31:24],   lb_state);

    @(negedge clock);
    chk_idle("final", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
